// File: rtl/lab4_net_terminal_adapter_if.sv
// Client- and router-facing handshake bundle for one ring terminal adapter.
// Header layout on the net side is {dest, src, opaque}, dest in the MSBs.
interface lab4_net_terminal_adapter_if #(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_dest_nbits    = 4,
  parameter int unsigned p_src_nbits     = 4,
  parameter int unsigned p_opaque_nbits  = 8
);
  localparam int unsigned c_hdr_nbits = p_dest_nbits + p_src_nbits + p_opaque_nbits;

  logic [p_dest_nbits-1:0]    cl_req_dest;
  logic [p_payload_nbits-1:0] cl_req_payload;
  logic                       cl_req_val;
  logic                       cl_req_rdy;

  logic [c_hdr_nbits-1:0]     net_out_msg_hdr;
  logic [p_payload_nbits-1:0] net_out_msg_payload;
  logic                       net_out_val;
  logic                       net_out_rdy;

  logic [c_hdr_nbits-1:0]     net_in_msg_hdr;
  logic [p_payload_nbits-1:0] net_in_msg_payload;
  logic                       net_in_val;
  logic                       net_in_rdy;

  logic [p_src_nbits-1:0]     cl_resp_src;
  logic [p_opaque_nbits-1:0]  cl_resp_opaque;
  logic [p_payload_nbits-1:0] cl_resp_payload;
  logic                       cl_resp_val;
  logic                       cl_resp_rdy;

  // Adapter side.
  modport master (
    input  cl_req_dest, cl_req_payload, cl_req_val,
    output cl_req_rdy,
    output net_out_msg_hdr, net_out_msg_payload, net_out_val,
    input  net_out_rdy,
    input  net_in_msg_hdr, net_in_msg_payload, net_in_val,
    output net_in_rdy,
    output cl_resp_src, cl_resp_opaque, cl_resp_payload, cl_resp_val,
    input  cl_resp_rdy
  );

  // Client / router side.
  modport slave (
    output cl_req_dest, cl_req_payload, cl_req_val,
    input  cl_req_rdy,
    input  net_out_msg_hdr, net_out_msg_payload, net_out_val,
    output net_out_rdy,
    output net_in_msg_hdr, net_in_msg_payload, net_in_val,
    input  net_in_rdy,
    input  cl_resp_src, cl_resp_opaque, cl_resp_payload, cl_resp_val,
    output cl_resp_rdy
  );
endinterface

// File: rtl/lab4_net_terminal_adapter.sv
// Ring terminal adapter: stamps and queues client requests toward the router,
// filters and queues router ejections toward the client, with statistics.
module lab4_net_terminal_adapter #(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_router_id     = 0,
  parameter int unsigned p_cnt_nbits     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  lab4_net_terminal_adapter_if.master bus,
  output logic                       misroute_err,
  output logic [p_cnt_nbits-1:0]     inj_count,
  output logic [p_cnt_nbits-1:0]     ej_count
);
  localparam int unsigned c_dest_nbits   = 4;
  localparam int unsigned c_src_nbits    = 4;
  localparam int unsigned c_opaque_nbits = 8;
  localparam logic [c_dest_nbits-1:0] c_id = c_dest_nbits'(p_router_id);
  localparam logic [c_src_nbits-1:0]  c_src = c_src_nbits'(p_router_id);

  typedef struct packed {
    logic [c_dest_nbits-1:0]   dest;
    logic [c_src_nbits-1:0]    src;
    logic [c_opaque_nbits-1:0] opaque;
  } net_hdr_t;

  typedef struct packed {
    net_hdr_t                   hdr;
    logic [p_payload_nbits-1:0] payload;
  } inj_entry_t;

  typedef struct packed {
    logic [c_src_nbits-1:0]     src;
    logic [c_opaque_nbits-1:0]  opaque;
    logic [p_payload_nbits-1:0] payload;
  } ej_entry_t;

  // ---------------------------------------------------------------- inject
  inj_entry_t                r_inj_mem [2];
  logic                      r_inj_head;
  logic                      r_inj_tail;
  logic [1:0]                r_inj_count;
  logic [c_opaque_nbits-1:0] r_seq;

  logic       w_inj_enq;
  logic       w_inj_deq;
  inj_entry_t w_inj_head;
  inj_entry_t w_inj_new;

  // Handshake outputs are forced low while reset is held, so no transfer
  // can happen on a reset cycle regardless of queue state.
  assign bus.cl_req_rdy  = reset && (r_inj_count < 2'd2);
  assign bus.net_out_val = reset && (r_inj_count != 2'd0);

  assign w_inj_enq  = bus.cl_req_val && bus.cl_req_rdy;
  assign w_inj_deq  = bus.net_out_val && bus.net_out_rdy;
  assign w_inj_head = r_inj_mem[r_inj_head];

  always_comb begin
    w_inj_new            = '0;
    w_inj_new.hdr.dest   = bus.cl_req_dest;
    w_inj_new.hdr.src    = c_src;
    w_inj_new.hdr.opaque = r_seq;
    w_inj_new.payload    = bus.cl_req_payload;
  end

  assign bus.net_out_msg_hdr     = reset ? w_inj_head.hdr     : '0;
  assign bus.net_out_msg_payload = reset ? w_inj_head.payload : '0;

  always_ff @(posedge clk) begin
    if (w_inj_enq) begin
      r_inj_mem[r_inj_tail] <= w_inj_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inj_head  <= 1'b0;
      r_inj_tail  <= 1'b0;
      r_inj_count <= 2'd0;
      r_seq       <= '0;
    end else begin
      if (w_inj_enq) begin
        r_inj_tail <= ~r_inj_tail;
        r_seq      <= r_seq + 1'b1;
      end
      if (w_inj_deq) begin
        r_inj_head <= ~r_inj_head;
      end
      case ({w_inj_enq, w_inj_deq})
        2'b10:   r_inj_count <= r_inj_count + 2'd1;
        2'b01:   r_inj_count <= r_inj_count - 2'd1;
        default: r_inj_count <= r_inj_count;
      endcase
    end
  end

  // ----------------------------------------------------------------- eject
  ej_entry_t  r_ej_mem [2];
  logic       r_ej_head;
  logic       r_ej_tail;
  logic [1:0] r_ej_count;
  logic       r_misroute;

  net_hdr_t  w_ej_in_hdr;
  logic      w_ej_acc;
  logic      w_ej_match;
  logic      w_ej_enq;
  logic      w_ej_deq;
  ej_entry_t w_ej_head;
  ej_entry_t w_ej_new;

  assign bus.net_in_rdy  = reset && (r_ej_count < 2'd2);
  assign bus.cl_resp_val = reset && (r_ej_count != 2'd0);

  assign w_ej_in_hdr = bus.net_in_msg_hdr;
  assign w_ej_acc    = bus.net_in_val && bus.net_in_rdy;
  assign w_ej_match  = (w_ej_in_hdr.dest == c_id);
  // Misrouted messages are still consumed so the router port never stalls.
  assign w_ej_enq    = w_ej_acc && w_ej_match;
  assign w_ej_deq    = bus.cl_resp_val && bus.cl_resp_rdy;
  assign w_ej_head   = r_ej_mem[r_ej_head];

  always_comb begin
    w_ej_new         = '0;
    w_ej_new.src     = w_ej_in_hdr.src;
    w_ej_new.opaque  = w_ej_in_hdr.opaque;
    w_ej_new.payload = bus.net_in_msg_payload;
  end

  assign bus.cl_resp_src     = reset ? w_ej_head.src     : '0;
  assign bus.cl_resp_opaque  = reset ? w_ej_head.opaque  : '0;
  assign bus.cl_resp_payload = reset ? w_ej_head.payload : '0;

  always_ff @(posedge clk) begin
    if (w_ej_enq) begin
      r_ej_mem[r_ej_tail] <= w_ej_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ej_head  <= 1'b0;
      r_ej_tail  <= 1'b0;
      r_ej_count <= 2'd0;
      r_misroute <= 1'b0;
    end else begin
      if (w_ej_enq) begin
        r_ej_tail <= ~r_ej_tail;
      end
      if (w_ej_deq) begin
        r_ej_head <= ~r_ej_head;
      end
      if (w_ej_acc && !w_ej_match) begin
        r_misroute <= 1'b1;
      end
      case ({w_ej_enq, w_ej_deq})
        2'b10:   r_ej_count <= r_ej_count + 2'd1;
        2'b01:   r_ej_count <= r_ej_count - 2'd1;
        default: r_ej_count <= r_ej_count;
      endcase
    end
  end

  assign misroute_err = r_misroute;

  // ------------------------------------------------------------ statistics
  logic [p_cnt_nbits-1:0] r_inj_stat;
  logic [p_cnt_nbits-1:0] r_ej_stat;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inj_stat <= '0;
      r_ej_stat  <= '0;
    end else begin
      if (w_inj_deq && (r_inj_stat != '1)) begin
        r_inj_stat <= r_inj_stat + 1'b1;
      end
      if (w_ej_deq && (r_ej_stat != '1)) begin
        r_ej_stat <= r_ej_stat + 1'b1;
      end
    end
  end

  assign inj_count = r_inj_stat;
  assign ej_count  = r_ej_stat;
endmodule
